switch_output_arbiter: RTL and testbench

- Per-output-port scheduler for the 4-port switch: one instance per output port.
- Takes the four input-port packet lanes and selects only packets whose target equals this port's ID.
- Shares the single output between contending inputs with round-robin fairness.
- Holds the winning packet in an output register until the downstream consumer accepts it.
- Sits between the input-side port lanes and the output-side port signals (valid_out/source_out/target_out/data_out).

---
 rtl/switch_pkg.sv | 20 ++
 rtl/switch_output_arbiter_if.sv | 30 +++
 rtl/switch_output_arbiter_rr_arbiter.sv | 45 ++++
 rtl/switch_output_arbiter.sv | 87 ++++++++
 tb/tb_switch_output_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/switch_pkg.sv
// Shared switch packet types and constants.
// Also holds the modulo-N pointer helper used by the round-robin arbiter.
package switch_pkg;

  localparam int unsigned PORT_W  = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned N_PORTS = 4;

  typedef struct packed {
    logic [PORT_W-1:0] source;
    logic [PORT_W-1:0] target;
    logic [DATA_W-1:0] data;
  } pkt_t;

  // Increment a lane index with wrap at n.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n = N_PORTS);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/switch_output_arbiter_if.sv
// Input lanes and output port of one switch output scheduler.
interface switch_output_arbiter_if
  import switch_pkg::*;
#(
  parameter int unsigned N_PORTS = 4
);

  logic [N_PORTS-1:0]        req_valid;
  logic [N_PORTS*PORT_W-1:0] req_source;
  logic [N_PORTS*PORT_W-1:0] req_target;
  logic [N_PORTS*DATA_W-1:0] req_data;
  logic [N_PORTS-1:0]        req_ready;

  logic              valid_out;
  logic [PORT_W-1:0] source_out;
  logic [PORT_W-1:0] target_out;
  logic [DATA_W-1:0] data_out;
  logic              out_ready;

  modport master (
    output req_valid, req_source, req_target, req_data, out_ready,
    input  req_ready, valid_out, source_out, target_out, data_out
  );

  modport slave (
    input  req_valid, req_source, req_target, req_data, out_ready,
    output req_ready, valid_out, source_out, target_out, data_out
  );

endinterface

// File: rtl/switch_output_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans from rr_ptr upward and moves the pointer
// past the winner whenever the grant is actually taken.
module rr_arbiter
  import switch_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] idx;
  logic             found;

  // N is a power of two, so IDX_W-bit addition wraps mod N for free.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = rr_ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    grant = found ? (N'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= IDX_W'(next_ptr(32'(grant_idx), N));
    end
  end

endmodule

// File: rtl/switch_output_arbiter.sv
// Per-output-port scheduler: filters lanes addressed to PORT_ID, arbitrates
// round-robin and holds the winning packet until downstream accepts it.
module switch_output_arbiter
  import switch_pkg::*;
#(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned PORT_ID = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  switch_output_arbiter_if.slave     bus,
  output logic [$clog2(N_PORTS)-1:0] grant_id,
  output logic [CNT_W-1:0]           pkt_count
);

  localparam int unsigned IDX_W = $clog2(N_PORTS);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state;
  state_t             state_next;
  pkt_t               lane_pkt [N_PORTS];
  pkt_t               out_pkt;
  logic [N_PORTS-1:0] elig;
  logic [N_PORTS-1:0] grant;
  logic [IDX_W-1:0]   win_idx;
  logic               load_en;
  logic               transfer;

  // Unpack lanes and keep only those addressed to this port.
  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      lane_pkt[i].source = bus.req_source[i*PORT_W +: PORT_W];
      lane_pkt[i].target = bus.req_target[i*PORT_W +: PORT_W];
      lane_pkt[i].data   = bus.req_data[i*DATA_W +: DATA_W];
      elig[i] = bus.req_valid[i] && (bus.req_target[i*PORT_W +: PORT_W] == PORT_W'(PORT_ID));
    end
  end

  rr_arbiter #(.N(N_PORTS)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (elig),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (win_idx)
  );

  assign load_en       = (state == EMPTY) || bus.out_ready;
  assign bus.req_ready = (rst_n && load_en) ? grant : '0;
  assign transfer      = |bus.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (transfer) state_next = FULL;
      FULL:    if (bus.out_ready && !transfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Output register and saturating accepted-packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pkt   <= '0;
      grant_id  <= '0;
      pkt_count <= '0;
    end else if (transfer) begin
      out_pkt  <= lane_pkt[win_idx];
      grant_id <= win_idx;
      if (pkt_count != {CNT_W{1'b1}}) pkt_count <= pkt_count + CNT_W'(1);
    end
  end

  assign bus.valid_out  = (state == FULL);
  assign bus.source_out = out_pkt.source;
  assign bus.target_out = out_pkt.target;
  assign bus.data_out   = out_pkt.data;

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Randomized and directed checks of switch_output_arbiter against a
// packet-level reference model (PORT_ID=2, 4-bit counter).
module tb_switch_output_arbiter;
  import switch_pkg::*;

  localparam int NP  = 4;
  localparam int PID = 2;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_output_arbiter_if #(.N_PORTS(NP)) bus ();
  logic [1:0]    grant_id;
  logic [CW-1:0] pkt_count;

  switch_output_arbiter #(.N_PORTS(NP), .PORT_ID(PID), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .grant_id  (grant_id),
    .pkt_count (pkt_count)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state: the single held packet, its lane, the count, the
  // lane to start the next fairness scan from.
  bit   m_valid;
  int   m_src, m_tgt, m_data, m_gid, m_cnt, m_ptr;
  logic [3:0] last_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_src = 0; m_tgt = 0; m_data = 0; m_gid = 0; m_cnt = 0; m_ptr = 0;
  endtask

  task automatic set_lane(input int l, input bit v, input int src, input int tgt, input int data);
    bus.req_valid[l]          = v;
    bus.req_source[4*l +: 4]  = 4'(src);
    bus.req_target[4*l +: 4]  = 4'(tgt);
    bus.req_data[8*l +: 8]    = 8'(data);
  endtask

  function automatic int find_winner();
    for (int k = 0; k < NP; k++) begin
      int l = (m_ptr + k) % NP;
      if (bus.req_valid[l] === 1'b1 && int'(bus.req_target[4*l +: 4]) == PID) return l;
    end
    return -1;
  endfunction

  task automatic check_out();
    check("valid_out", 32'(bus.valid_out), 32'(m_valid));
    check("source_out", 32'(bus.source_out), 32'(m_src));
    check("target_out", 32'(bus.target_out), 32'(m_tgt));
    check("data_out", 32'(bus.data_out), 32'(m_data));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    check("pkt_count", 32'(pkt_count), 32'(m_cnt));
  endtask

  // One clock: check ready against the model, take the edge, check outputs.
  task automatic step();
    int w;
    bit load;
    logic [3:0] er;
    #1;
    load = !m_valid || bus.out_ready;
    w = find_winner();
    er = (load && w >= 0) ? 4'(1 << w) : 4'b0;
    check("req_ready", 32'(bus.req_ready), 32'(er));
    last_rdy = bus.req_ready;
    if (er != 0) begin
      m_src  = int'(bus.req_source[4*w +: 4]);
      m_tgt  = int'(bus.req_target[4*w +: 4]);
      m_data = int'(bus.req_data[8*w +: 8]);
    end
    @(posedge clk);
    if (er != 0) begin
      m_valid = 1;
      m_gid   = w;
      m_ptr   = (w + 1) % NP;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_count", 32'(pkt_count), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_lanes();
    for (int l = 0; l < NP; l++) set_lane(l, 0, 0, 0, 0);
  endtask

  initial begin
    clear_lanes();
    bus.out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_out();

    // Single lane 1 -> port 2
    set_lane(1, 1, 1, 2, 'hA5);
    bus.out_ready = 1'b1;
    step();
    check("single_rdy", 32'(last_rdy), 32'b0010);
    check("single_valid", 32'(bus.valid_out), 32'd1);
    check("single_data", 32'(bus.data_out), 32'hA5);
    check("single_gid", 32'(grant_id), 32'd1);
    check("single_cnt", 32'(pkt_count), 32'd1);
    set_lane(1, 0, 1, 2, 'hA5);
    step();

    // Lane addressed elsewhere is never served
    set_lane(0, 1, 0, 3, 'h11);
    for (int i = 0; i < 10; i++) begin
      step();
      check("filt_rdy0", 32'(last_rdy[0]), 32'd0);
      check("filt_valid", 32'(bus.valid_out), 32'd0);
    end
    clear_lanes();

    // Fairness rotation from a fresh pointer
    do_reset();
    for (int l = 0; l < NP; l++) set_lane(l, 1, l, PID, 'h10 + l);
    for (int i = 0; i < 8; i++) begin
      step();
      check("fair_gid", 32'(grant_id), 32'(i % NP));
      check("fair_data", 32'(bus.data_out), 32'('h10 + i % NP));
    end
    check("fair_cnt", 32'(pkt_count), 32'd8);
    clear_lanes();

    // Backpressure holds lane 0's packet, then lane 3 follows
    do_reset();
    set_lane(0, 1, 0, PID, 'hC0);
    set_lane(3, 1, 3, PID, 'hC3);
    bus.out_ready = 1'b1;
    step();
    set_lane(0, 0, 0, PID, 'hC0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_rdy", 32'(last_rdy), 32'd0);
      check("bp_data", 32'(bus.data_out), 32'hC0);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_rdy3", 32'(last_rdy), 32'b1000);
    check("bp_data3", 32'(bus.data_out), 32'hC3);
    check("bp_gid3", 32'(grant_id), 32'd3);
    clear_lanes();
    step();
    check("bp_drain", 32'(bus.valid_out), 32'd0);
    check("bp_cnt", 32'(pkt_count), 32'd2);

    // Counter saturation, then reset mid-burst
    do_reset();
    for (int l = 0; l < NP; l++) set_lane(l, 1, l, PID, 'h20 + l);
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt", 32'(pkt_count), 32'hF);
    check("burst_valid", 32'(bus.valid_out), 32'd1);
    do_reset();
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int l = 0; l < NP; l++)
        set_lane(l, ($urandom % 4) != 0, $urandom % 16,
                 ($urandom % 2) ? PID : int'($urandom % 16), $urandom % 256);
      bus.out_ready = ($urandom % 3) != 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
